writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Writeback stage that sits directly upstream of the register array write port and drives its write_enable, write_reg_address and write_data.
- Merges two result producers, the ALU and the load unit, each over a valid/ready handshake, and performs one register write per cycle.
- Sign- or zero-extends load data to register width.
- Guarantees the ALU is never starved by a long run of loads.

Parameters:
- register_num, 32, number of architectural registers; address width is $clog2(register_num).
- register_width, 32, data width in bits; must be at least 32.
- starve_limit, 4, maximum number of consecutive cycles a valid ALU result may be blocked before it is forcibly granted. Must be 1..15.
- zero_reg_discard, 1, when 1 writes to address 0 are accepted but dropped (write_enable stays 0).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- alu_valid  input  1  ALU result present.
- alu_ready  output  1  ALU result accepted this cycle.
- alu_rd  input  AW  ALU destination register address.
- alu_data  input  register_width  ALU result.
- ld_valid  input  1  load result present.
- ld_ready  output  1  load result accepted this cycle.
- ld_rd  input  AW  load destination register address.
- ld_data  input  32  raw memory word.
- ld_size  input  2  load size: 0 = byte, 1 = half, 2 = word, 3 = reserved, treated as word.
- ld_offset  input  2  byte offset of the access within the word.
- ld_unsigned  input  1  1 = zero-extend, 0 = sign-extend.
- write_enable  output  1  to register array.
- write_reg_address  output  AW  to register array.
- write_data  output  register_width  to register array.
- starve_count  output  4  current starvation counter, for debug.

Behaviour:
- Reset (rst = 0, asynchronous):
  - write_enable = 0, write_reg_address = 0, write_data = 0.
  - Starvation counter = 0.
  - alu_ready = 0 and ld_ready = 0 while rst is low.
- Handshake: a transfer occurs on a rising edge when valid && ready. Producers hold rd and data stable while valid && !ready.
- Arbitration is combinational from the current inputs and the counter:
  - force_alu = alu_valid && (counter == starve_limit).
  - ld_ready = !force_alu.
  - alu_ready = !ld_valid || force_alu.
  - At most one grant per cycle. With both valid and force_alu = 0, the load wins.
  - ready may assert without valid; no transfer occurs in that case.
- Starvation counter, updated at each rising edge:
  - Cleared when the ALU transfers or alu_valid = 0.
  - Incremented when alu_valid && !alu_ready.
  - Saturates at starve_limit.
- Latency: exactly one cycle. A transfer at edge N drives the write_* outputs for the cycle after edge N, and the register array samples them at edge N+1.
- When no transfer occurs at an edge, write_enable = 0 for the next cycle. write_reg_address and write_data hold their previous values.
- Load extension:
  - Byte: lane = ld_data[8*ld_offset +: 8].
  - Half: lane = ld_data[16*ld_offset[1] +: 16]; ld_offset[0] is ignored (no misalignment trap).
  - Word: lane = ld_data.
  - The lane is sign- or zero-extended per ld_unsigned to register_width.
  - For word loads with register_width > 32, ld_unsigned selects the extension of bit 31.
  - ALU data passes unmodified.
- Zero register: with zero_reg_discard = 1, a transfer with rd = 0 completes the handshake, leaves write_enable = 0 for the next cycle, and counts as an ALU grant for counter purposes.
- Reset mid-operation: any result registered but not yet written is lost. The producers' handshake restarts after rst rises.
- No bypass path: the register array's own read-during-write behaviour governs hazards.

Decomposition:
- Shared package cpu_pkg holds:
  - localparams for the ld_size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD).
  - the AW derivation function.
  - default register_num and register_width, shared with register_array.
- One natural sub-module: load_extend, purely combinational, taking ld_data, ld_size, ld_offset and ld_unsigned to extended data. It is reused by the future load/store unit.
- Arbitration, the counter and the output register stay in the top module.

Test Plan:
- Reset: hold rst = 0 for 2 cycles with both channels valid. Expect write_enable = 0, both readies 0, starve_count = 0. Deassert rst, then an ALU write of rd = 3, data = 10 appears with write_enable = 1 exactly one cycle after the handshake edge.
- Extension: load word 0x8081_F0FF.
  - Byte offset 1 signed gives 0xFFFF_FFF0.
  - Byte offset 1 unsigned gives 0x0000_00F0.
  - Half offset 2 signed gives 0xFFFF_8081.
  - Word gives 0x8081_F0FF.
- Contention: alu_valid and ld_valid held for 10 cycles with starve_limit = 4. The load is granted on cycles 0–3, the ALU is forced on cycle 4 (starve_count = 4 → 0), then loads resume. Check the write_data sequence matches the grant order.
- Zero register: ALU rd = 0, data = 50, with zero_reg_discard = 1. Expect alu_ready = 1 and write_enable = 0 next cycle. Rerun with zero_reg_discard = 0 and expect write_enable = 1, address 0, data 50.
- Idle and backpressure: ALU only with rd = 9, data = -10 every cycle. alu_ready stays 1, one write per cycle with write_data = 0xFFFF_FFF6, and starve_count stays 0.
- Reset mid-stream: assert rst between the handshake edge and the write edge. Expect write_enable to drop to 0 immediately (asynchronous) and no write of the pending result after rst releases.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register file geometry defaults and load size encodings.
package cpu_pkg;

  localparam int unsigned REGISTER_NUM   = 32;
  localparam int unsigned REGISTER_WIDTH = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } ld_size_e;

  // Register address width; a single-register file still needs one address bit.
  function automatic int unsigned addr_width(input int unsigned num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Writeback bundle: ALU and load producer handshakes plus the register array write port.
interface writeback_arbiter_if #(
    parameter int unsigned register_num   = cpu_pkg::REGISTER_NUM,
    parameter int unsigned register_width = cpu_pkg::REGISTER_WIDTH
);

    localparam int unsigned AW = cpu_pkg::addr_width(register_num);

    logic                      alu_valid;
    logic                      alu_ready;
    logic [AW-1:0]             alu_rd;
    logic [register_width-1:0] alu_data;

    logic                      ld_valid;
    logic                      ld_ready;
    logic [AW-1:0]             ld_rd;
    logic [31:0]               ld_data;
    logic [1:0]                ld_size;
    logic [1:0]                ld_offset;
    logic                      ld_unsigned;

    logic                      write_enable;
    logic [AW-1:0]             write_reg_address;
    logic [register_width-1:0] write_data;
    logic [3:0]                starve_count;

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  ld_valid, ld_rd, ld_data, ld_size, ld_offset, ld_unsigned,
        output ld_ready,
        output write_enable, write_reg_address, write_data, starve_count
    );

    // Producer / register array side.
    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output ld_valid, ld_rd, ld_data, ld_size, ld_offset, ld_unsigned,
        input  ld_ready,
        input  write_enable, write_reg_address, write_data, starve_count
    );

endinterface

// File: rtl/writeback_arbiter_load_extend.sv
// Purely combinational load lane select and sign/zero extension to register width.
module load_extend
    import cpu_pkg::*;
#(
    parameter int unsigned register_width = REGISTER_WIDTH
) (
    input  logic [31:0]               ld_data,
    input  logic [1:0]                ld_size,
    input  logic [1:0]                ld_offset,
    input  logic                      ld_unsigned,
    output logic [register_width-1:0] ext_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        fill;

    always_comb begin
        byte_lane = ld_data[{ld_offset, 3'b000} +: 8];
        // Half loads ignore offset bit 0: misaligned halves read the aligned half.
        half_lane = ld_data[{ld_offset[1], 4'b0000} +: 16];
        fill      = 1'b0;
        ext_data  = '0;
        case (ld_size)
            SIZE_BYTE: begin
                fill           = !ld_unsigned && byte_lane[7];
                ext_data       = {register_width{fill}};
                ext_data[7:0]  = byte_lane;
            end
            SIZE_HALF: begin
                fill           = !ld_unsigned && half_lane[15];
                ext_data       = {register_width{fill}};
                ext_data[15:0] = half_lane;
            end
            default: begin
                fill           = !ld_unsigned && ld_data[31];
                ext_data       = {register_width{fill}};
                ext_data[31:0] = ld_data;
            end
        endcase
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU and load results into one registered register-file write per cycle.
module writeback_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned register_num     = REGISTER_NUM,
    parameter int unsigned register_width   = REGISTER_WIDTH,
    parameter int unsigned starve_limit     = 4,
    parameter bit          zero_reg_discard = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    writeback_arbiter_if.slave wb
);

    localparam int unsigned AW = addr_width(register_num);
    localparam logic [3:0]  LIMIT = 4'(starve_limit);

    logic [3:0]                counter;
    logic                      force_alu;
    logic                      ld_xfer;
    logic                      alu_xfer;
    logic [register_width-1:0] ld_ext;

    logic                      sel_xfer;
    logic                      sel_we;
    logic [AW-1:0]             sel_rd;
    logic [register_width-1:0] sel_data;

    load_extend #(
        .register_width(register_width)
    ) u_load_extend (
        .ld_data    (wb.ld_data),
        .ld_size    (wb.ld_size),
        .ld_offset  (wb.ld_offset),
        .ld_unsigned(wb.ld_unsigned),
        .ext_data   (ld_ext)
    );

    // Readies are gated by reset so neither producer sees an accept while rst is low.
    always_comb begin
        force_alu    = wb.alu_valid && (counter == LIMIT);
        wb.ld_ready  = rst && !force_alu;
        wb.alu_ready = rst && (!wb.ld_valid || force_alu);
        ld_xfer      = wb.ld_valid && wb.ld_ready;
        alu_xfer     = wb.alu_valid && wb.alu_ready;
    end

    always_comb begin
        sel_xfer = ld_xfer || alu_xfer;
        sel_rd   = ld_xfer ? wb.ld_rd : wb.alu_rd;
        sel_data = ld_xfer ? ld_ext : wb.alu_data;
        sel_we   = sel_xfer && !(zero_reg_discard && (sel_rd == '0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter <= '0;
        end else if (!wb.alu_valid || alu_xfer) begin
            counter <= '0;
        end else if (counter != LIMIT) begin
            counter <= counter + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb.write_enable      <= 1'b0;
            wb.write_reg_address <= '0;
            wb.write_data        <= '0;
        end else if (sel_xfer) begin
            wb.write_enable      <= sel_we;
            wb.write_reg_address <= sel_rd;
            wb.write_data        <= sel_data;
        end else begin
            wb.write_enable      <= 1'b0;
        end
    end

    always_comb wb.starve_count = counter;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter (discarding and non-discarding instances).
module tb_writeback_arbiter;

    localparam int unsigned RN = 32;
    localparam int unsigned RW = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    writeback_arbiter_if #(.register_num(RN), .register_width(RW)) wa ();
    writeback_arbiter_if #(.register_num(RN), .register_width(RW)) wb0 ();

    writeback_arbiter #(
        .register_num(RN), .register_width(RW), .starve_limit(4), .zero_reg_discard(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .wb(wa.slave)
    );

    writeback_arbiter #(
        .register_num(RN), .register_width(RW), .starve_limit(4), .zero_reg_discard(1'b0)
    ) dut_keep0 (
        .clk(clk), .rst(rst), .wb(wb0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wa.alu_valid = 0; wa.alu_rd = '0; wa.alu_data = '0;
        wa.ld_valid = 0; wa.ld_rd = '0; wa.ld_data = '0;
        wa.ld_size = 2'd2; wa.ld_offset = 2'd0; wa.ld_unsigned = 0;
        wb0.alu_valid = 0; wb0.alu_rd = '0; wb0.alu_data = '0;
        wb0.ld_valid = 0; wb0.ld_rd = '0; wb0.ld_data = '0;
        wb0.ld_size = 2'd2; wb0.ld_offset = 2'd0; wb0.ld_unsigned = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        wa.alu_valid = 1; wa.alu_rd = 5'd4; wa.alu_data = 32'h1111_1111;
        wa.ld_valid = 1; wa.ld_rd = 5'd6; wa.ld_data = 32'h2222_2222;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (wa.write_enable !== 1'b0) begin errors++; $display("FAIL reset_we actual=%0h required=0", wa.write_enable); end
        checks++; if (wa.alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready actual=%0h required=0", wa.alu_ready); end
        checks++; if (wa.ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready actual=%0h required=0", wa.ld_ready); end
        checks++; if (wa.starve_count !== 4'd0) begin errors++; $display("FAIL reset_starve actual=%0d required=0", wa.starve_count); end
        checks++; if (wa.write_reg_address !== 5'd0 || wa.write_data !== 32'd0) begin
            errors++; $display("FAIL reset_addr_data actual=%0h/%0h required=0/0", wa.write_reg_address, wa.write_data); end

        wa.ld_valid = 0; wa.alu_rd = 5'd3; wa.alu_data = 32'd10;
        rst = 1;
        #1;
        checks++; if (wa.alu_ready !== 1'b1) begin errors++; $display("FAIL post_reset_alu_ready actual=%0h required=1", wa.alu_ready); end
        checks++; if (wa.write_enable !== 1'b0) begin errors++; $display("FAIL pre_write_we actual=%0h required=0", wa.write_enable); end
        tick();
        checks++; if (wa.write_enable !== 1'b1 || wa.write_reg_address !== 5'd3 || wa.write_data !== 32'd10) begin
            errors++; $display("FAIL first_alu_write actual=%0h/%0d/%0d required=1/3/10",
                               wa.write_enable, wa.write_reg_address, wa.write_data); end
        wa.alu_valid = 0;
        tick();
        checks++; if (wa.write_enable !== 1'b0 || wa.write_reg_address !== 5'd3 || wa.write_data !== 32'd10) begin
            errors++; $display("FAIL idle_hold actual=%0h/%0d/%0d required=0/3/10",
                               wa.write_enable, wa.write_reg_address, wa.write_data); end
    endtask

    task automatic test_extend();
        logic [1:0]  sz  [8];
        logic [1:0]  off [8];
        logic        uns [8];
        logic [31:0] exp [8];
        sz  = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd3, 2'd0};
        off = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd3, 2'd3, 2'd1, 2'd0};
        uns = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8081, 32'h8081_F0FF,
                32'hFFFF_FF80, 32'h0000_8081, 32'h8081_F0FF, 32'hFFFF_FFFF};
        wa.alu_valid = 0;
        wa.ld_data = 32'h8081_F0FF;
        for (int i = 0; i < 8; i++) begin
            wa.ld_valid = 1; wa.ld_rd = 5'(i + 1);
            wa.ld_size = sz[i]; wa.ld_offset = off[i]; wa.ld_unsigned = uns[i];
            tick();
            checks++; if (wa.write_enable !== 1'b1 || wa.write_reg_address !== 5'(i + 1) || wa.write_data !== exp[i]) begin
                errors++; $display("FAIL extend_%0d actual=%0h/%0d/%h required=1/%0d/%h",
                                   i, wa.write_enable, wa.write_reg_address, wa.write_data, i + 1, exp[i]); end
        end
        wa.ld_valid = 0;
        tick();
    endtask

    task automatic test_contention();
        int          alu_n;
        int          ld_n;
        logic        alu_turn;
        logic [3:0]  exp_cnt;
        logic [31:0] exp_data;
        alu_n = 0; ld_n = 0;
        wa.ld_size = 2'd2; wa.ld_offset = 2'd0; wa.ld_unsigned = 0;
        wa.alu_valid = 1; wa.alu_rd = 5'd1;
        wa.ld_valid = 1; wa.ld_rd = 5'd2;
        for (int c = 0; c < 10; c++) begin
            wa.alu_data = 32'hAAAA_0000 + 32'(alu_n);
            wa.ld_data  = 32'h1000_0000 + 32'(ld_n);
            alu_turn = (c == 4) || (c == 9);
            exp_cnt  = (c < 5) ? 4'(c) : 4'(c - 5);
            #1;
            checks++; if (wa.starve_count !== exp_cnt) begin
                errors++; $display("FAIL contention_count_%0d actual=%0d required=%0d", c, wa.starve_count, exp_cnt); end
            checks++; if (wa.alu_ready !== alu_turn || wa.ld_ready !== !alu_turn) begin
                errors++; $display("FAIL contention_ready_%0d actual=%0h/%0h required=%0h/%0h",
                                   c, wa.alu_ready, wa.ld_ready, alu_turn, !alu_turn); end
            exp_data = alu_turn ? 32'hAAAA_0000 + 32'(alu_n) : 32'h1000_0000 + 32'(ld_n);
            tick();
            checks++; if (wa.write_enable !== 1'b1 || wa.write_data !== exp_data) begin
                errors++; $display("FAIL contention_data_%0d actual=%0h/%h required=1/%h",
                                   c, wa.write_enable, wa.write_data, exp_data); end
            if (alu_turn) alu_n++; else ld_n++;
        end
        wa.alu_valid = 0; wa.ld_valid = 0;
        tick();
        checks++; if (wa.starve_count !== 4'd0 || wa.write_enable !== 1'b0) begin
            errors++; $display("FAIL contention_drain actual=%0d/%0h required=0/0", wa.starve_count, wa.write_enable); end
    endtask

    task automatic test_zero_reg();
        wa.alu_valid = 1; wa.alu_rd = 5'd0; wa.alu_data = 32'd50; wa.ld_valid = 0;
        wb0.alu_valid = 1; wb0.alu_rd = 5'd0; wb0.alu_data = 32'd50; wb0.ld_valid = 0;
        #1;
        checks++; if (wa.alu_ready !== 1'b1 || wb0.alu_ready !== 1'b1) begin
            errors++; $display("FAIL zero_ready actual=%0h/%0h required=1/1", wa.alu_ready, wb0.alu_ready); end
        tick();
        wa.alu_valid = 0; wb0.alu_valid = 0;
        checks++; if (wa.write_enable !== 1'b0) begin
            errors++; $display("FAIL zero_discard_we actual=%0h required=0", wa.write_enable); end
        checks++; if (wa.starve_count !== 4'd0) begin
            errors++; $display("FAIL zero_discard_count actual=%0d required=0", wa.starve_count); end
        checks++; if (wb0.write_enable !== 1'b1 || wb0.write_reg_address !== 5'd0 || wb0.write_data !== 32'd50) begin
            errors++; $display("FAIL zero_keep_write actual=%0h/%0d/%0d required=1/0/50",
                               wb0.write_enable, wb0.write_reg_address, wb0.write_data); end
        tick();
    endtask

    task automatic test_idle_alu();
        wa.ld_valid = 0;
        wa.alu_valid = 1; wa.alu_rd = 5'd9; wa.alu_data = -32'sd10;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (wa.alu_ready !== 1'b1 || wa.starve_count !== 4'd0) begin
                errors++; $display("FAIL alu_only_ready_%0d actual=%0h/%0d required=1/0", i, wa.alu_ready, wa.starve_count); end
            tick();
            checks++; if (wa.write_enable !== 1'b1 || wa.write_reg_address !== 5'd9 || wa.write_data !== 32'hFFFF_FFF6) begin
                errors++; $display("FAIL alu_only_write_%0d actual=%0h/%0d/%h required=1/9/fffffff6",
                                   i, wa.write_enable, wa.write_reg_address, wa.write_data); end
        end
        wa.alu_valid = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        wa.alu_valid = 1; wa.alu_rd = 5'd5; wa.alu_data = 32'h0000_1234; wa.ld_valid = 0;
        tick();
        checks++; if (wa.write_enable !== 1'b1 || wa.write_reg_address !== 5'd5) begin
            errors++; $display("FAIL mid_pending actual=%0h/%0d required=1/5", wa.write_enable, wa.write_reg_address); end
        rst = 0;
        wa.alu_valid = 0;
        #1;
        checks++; if (wa.write_enable !== 1'b0 || wa.write_reg_address !== 5'd0 || wa.write_data !== 32'd0) begin
            errors++; $display("FAIL mid_async_clear actual=%0h/%0d/%h required=0/0/0",
                               wa.write_enable, wa.write_reg_address, wa.write_data); end
        @(negedge clk);
        rst = 1;
        tick();
        checks++; if (wa.write_enable !== 1'b0 || wa.write_data !== 32'd0) begin
            errors++; $display("FAIL mid_no_replay actual=%0h/%h required=0/0", wa.write_enable, wa.write_data); end
        tick();
        checks++; if (wa.write_enable !== 1'b0) begin
            errors++; $display("FAIL mid_quiet actual=%0h required=0", wa.write_enable); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 0;
        idle_inputs();
        test_reset();
        test_extend();
        test_contention();
        test_zero_reg();
        test_idle_alu();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
